// File: rtl/psa_reduce_ctrl.sv
// Reduction sequencer for a shared nibble-saturating adder: accumulates a stream
// of packed signed-nibble operands into one result with sticky per-lane saturation.
module psa_reduce_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [15:0]      init,
    input  logic             abort,
    input  logic             op_valid,
    input  logic [15:0]      op_data,
    output logic             op_ready,
    output logic             busy,
    output logic             done,
    output logic [15:0]      result,
    output logic [3:0]       sat_flags
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned LANES  = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_acc;
    logic [DATA_W-1:0]  w_acc_nxt;
    logic [CNT_W-1:0]   r_rem;
    logic [CNT_W-1:0]   w_rem_nxt;
    logic [LANES-1:0]   r_sat;
    logic [LANES-1:0]   w_sat_nxt;
    logic               r_op_ready;
    logic               r_busy;
    logic               r_done;
    logic [DATA_W-1:0]  r_result;
    logic [LANES-1:0]   r_sat_flags;
    logic [DATA_W-1:0]  w_psa_sum;
    logic [LANES-1:0]   w_psa_ovfl;
    logic               w_load_result;

    // Per-lane signed add with clamp to [-8, 7]; lanes are fully independent.
    always_comb begin
        logic [4:0] w_s;
        w_psa_sum  = '0;
        w_psa_ovfl = '0;
        w_s        = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_s = {r_acc[4*i+3], r_acc[4*i +: 4]} + {op_data[4*i+3], op_data[4*i +: 4]};
            if (w_s[4:3] == 2'b01) begin
                w_psa_sum[4*i +: 4] = 4'h7;
                w_psa_ovfl[i]       = 1'b1;
            end else if (w_s[4:3] == 2'b10) begin
                w_psa_sum[4*i +: 4] = 4'h8;
                w_psa_ovfl[i]       = 1'b1;
            end else begin
                w_psa_sum[4*i +: 4] = w_s[3:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_rem_nxt   = r_rem;
        w_sat_nxt   = r_sat;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_acc_nxt   = init;
                    w_rem_nxt   = count;
                    w_sat_nxt   = '0;
                    w_state_nxt = (count == CNT_W'(0)) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                // Abort wins over a same-cycle handshake; the operand is left unconsumed.
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (op_valid && r_op_ready) begin
                    w_acc_nxt = w_psa_sum;
                    w_sat_nxt = r_sat | w_psa_ovfl;
                    w_rem_nxt = r_rem - CNT_W'(1);
                    if (r_rem == CNT_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_load_result = (w_state_nxt == S_DONE) && (r_state != S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_rem       <= '0;
            r_sat       <= '0;
            r_op_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_sat_flags <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_rem      <= w_rem_nxt;
            r_sat      <= w_sat_nxt;
            r_op_ready <= (w_state_nxt == S_ACCUM);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_DONE);
            if (w_load_result) begin
                r_result    <= w_acc_nxt;
                r_sat_flags <= w_sat_nxt;
            end
        end
    end

    assign op_ready  = r_op_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign sat_flags = r_sat_flags;

endmodule

// File: tb/tb_psa_reduce_ctrl.sv
// Directed bench for psa_reduce_ctrl with hand-computed expected values.
module tb_psa_reduce_ctrl;

    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [15:0]      init;
    logic             abort;
    logic             op_valid;
    logic [15:0]      op_data;
    logic             op_ready;
    logic             busy;
    logic             done;
    logic [15:0]      result;
    logic [3:0]       sat_flags;

    int n_cmp  = 0;
    int n_fail = 0;

    psa_reduce_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .count     (count),
        .init      (init),
        .abort     (abort),
        .op_valid  (op_valid),
        .op_data   (op_data),
        .op_ready  (op_ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .sat_flags (sat_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic rdy, input logic bsy, input logic dn);
        chk({tag, ".op_ready"}, 16'(op_ready), 16'(rdy));
        chk({tag, ".busy"},     16'(busy),     16'(bsy));
        chk({tag, ".done"},     16'(done),     16'(dn));
    endtask

    task automatic start_job(input logic [CNT_W-1:0] c, input logic [15:0] iv);
        start = 1'b1;
        count = c;
        init  = iv;
        tick();
        start = 1'b0;
        count = '0;
        init  = '0;
    endtask

    task automatic send(input logic [15:0] d);
        op_valid = 1'b1;
        op_data  = d;
        tick();
        op_valid = 1'b0;
        op_data  = '0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        count    = '0;
        init     = '0;
        abort    = 1'b0;
        op_valid = 1'b0;
        op_data  = '0;
        tick();
        tick();
        chk_ctl("rst0", 1'b0, 1'b0, 1'b0);
        chk("rst0.result", result, 16'h0000);
        chk("rst0.sat", 16'(sat_flags), 16'h0000);
        rst_n = 1'b1;
        tick();

        // Basic three-operand job
        start_job(8'd3, 16'h0000);
        chk_ctl("basic.accum", 1'b1, 1'b1, 1'b0);
        send(16'h1111);
        send(16'h2222);
        chk_ctl("basic.mid", 1'b1, 1'b1, 1'b0);
        send(16'h3333);
        chk_ctl("basic.done", 1'b0, 1'b1, 1'b1);
        chk("basic.result", result, 16'h6666);
        chk("basic.sat", 16'(sat_flags), 16'h0000);
        tick();
        chk_ctl("basic.idle", 1'b0, 1'b0, 1'b0);
        chk("basic.hold", result, 16'h6666);

        // Abort with a same-cycle valid operand
        start_job(8'd4, 16'h0000);
        send(16'h1111);
        abort    = 1'b1;
        op_valid = 1'b1;
        op_data  = 16'h2222;
        tick();
        abort    = 1'b0;
        op_valid = 1'b0;
        op_data  = '0;
        chk_ctl("abort.idle", 1'b0, 1'b0, 1'b0);
        chk("abort.result", result, 16'h6666);
        tick();
        chk_ctl("abort.nodone", 1'b0, 1'b0, 1'b0);
        chk("abort.result2", result, 16'h6666);

        // Positive saturation in every lane
        start_job(8'd2, 16'h0000);
        send(16'h5555);
        send(16'h4444);
        chk_ctl("sat_a.done", 1'b0, 1'b1, 1'b1);
        chk("sat_a.result", result, 16'h7777);
        chk("sat_a.sat", 16'(sat_flags), 16'h000F);
        tick();

        // Negative saturation in lane 3 only
        start_job(8'd1, 16'h8000);
        send(16'hF001);
        chk_ctl("sat_b.done", 1'b0, 1'b1, 1'b1);
        chk("sat_b.result", result, 16'h8001);
        chk("sat_b.sat", 16'(sat_flags), 16'h0008);
        tick();

        // Zero-length job completes right after start
        start_job(8'd0, 16'hABCD);
        chk_ctl("zero.done", 1'b0, 1'b1, 1'b1);
        chk("zero.result", result, 16'hABCD);
        chk("zero.sat", 16'(sat_flags), 16'h0000);
        tick();
        chk_ctl("zero.idle", 1'b0, 1'b0, 1'b0);

        // Stalled stream plus a stray start pulse during ACCUM
        start_job(8'd2, 16'h0000);
        op_valid = 1'b1;
        op_data  = 16'h0101;
        start    = 1'b1;
        count    = 8'd0;
        init     = 16'hFFFF;
        tick();
        start    = 1'b0;
        count    = '0;
        init     = '0;
        op_valid = 1'b0;
        op_data  = 16'h0202;
        tick();
        chk_ctl("stall.gap1", 1'b1, 1'b1, 1'b0);
        tick();
        chk_ctl("stall.gap2", 1'b1, 1'b1, 1'b0);
        send(16'h0202);
        chk_ctl("stall.done", 1'b0, 1'b1, 1'b1);
        chk("stall.result", result, 16'h0303);
        chk("stall.sat", 16'(sat_flags), 16'h0000);
        tick();
        chk_ctl("stall.idle", 1'b0, 1'b0, 1'b0);

        // Fresh job after abort starts from init, not stale accumulator
        start_job(8'd1, 16'h0000);
        send(16'h1111);
        chk("fresh.result", result, 16'h1111);
        tick();

        // Reset asserted in the middle of ACCUM
        start_job(8'd3, 16'h0000);
        send(16'h1111);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_ctl("rst_mid", 1'b0, 1'b0, 1'b0);
        chk("rst_mid.result", result, 16'h0000);
        chk("rst_mid.sat", 16'(sat_flags), 16'h0000);
        tick();
        chk_ctl("rst_mid.after", 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
